// File: rtl/adc_spi_reader.sv
// LTC2308-style SPI ADC reader: runs back-to-back conversions while enabled and
// presents each 12-bit result as a registered word with a one-cycle valid strobe.
module adc_spi_reader #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int CHANNEL     = 0
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        enable,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic [11:0] adc_value,
  output logic        sample_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  localparam logic [2:0]  CH  = 3'(CHANNEL);
  // S/D, O/S, S1, S0, UNI, SLP followed by six zero pad bits
  localparam logic [11:0] CFG = {1'b1, CH[0], CH[2], CH[1], 1'b1, 1'b0, 6'b0};

  logic [1:0]    state_q,    state_d;
  logic [CW-1:0] conv_cnt_q, conv_cnt_d;
  logic [DW-1:0] div_q,      div_d;
  logic [3:0]    fall_cnt_q, fall_cnt_d;
  logic          sck_q,      sck_d;
  logic          convst_q,   convst_d;
  logic [11:0]   cfg_sr_q,   cfg_sr_d;
  logic [11:0]   shreg_q,    shreg_d;
  logic [11:0]   value_q,    value_d;
  logic          valid_q,    valid_d;
  logic          tick;

  assign tick = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    div_d      = div_q;
    fall_cnt_d = fall_cnt_q;
    sck_d      = sck_q;
    convst_d   = convst_q;
    cfg_sr_d   = cfg_sr_q;
    shreg_d    = shreg_q;
    value_d    = value_q;
    valid_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d    = S_CONV;
          convst_d   = 1'b1;
          conv_cnt_d = '0;
        end
      end

      S_CONV: begin
        if (conv_cnt_q == CW'(CONV_CYCLES - 1)) begin
          state_d    = S_SHIFT;
          convst_d   = 1'b0;
          cfg_sr_d   = CFG;
          div_d      = '0;
          fall_cnt_d = '0;
        end else begin
          conv_cnt_d = conv_cnt_q + CW'(1);
        end
      end

      S_SHIFT: begin
        if (tick) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            // rising SCK edge: capture result bit, MSB arrives first
            shreg_d = {shreg_q[10:0], adc_sdo};
          end else begin
            // falling SCK edge: present the next config bit
            cfg_sr_d   = {cfg_sr_q[10:0], 1'b0};
            fall_cnt_d = fall_cnt_q + 4'd1;
            if (fall_cnt_q == 4'd11) state_d = S_DONE;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      S_DONE: begin
        value_d = shreg_q;
        valid_d = 1'b1;
        if (enable) begin
          state_d    = S_CONV;
          convst_d   = 1'b1;
          conv_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      conv_cnt_q <= '0;
      div_q      <= '0;
      fall_cnt_q <= '0;
      sck_q      <= 1'b0;
      convst_q   <= 1'b0;
      cfg_sr_q   <= '0;
      shreg_q    <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      div_q      <= div_d;
      fall_cnt_q <= fall_cnt_d;
      sck_q      <= sck_d;
      convst_q   <= convst_d;
      cfg_sr_q   <= cfg_sr_d;
      shreg_q    <= shreg_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
    end
  end

  assign adc_convst   = convst_q;
  assign adc_sck      = sck_q;
  assign adc_sdi      = cfg_sr_q[11];
  assign adc_value    = value_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: behavioural ADC models feed SDO, a scoreboard queue
// holds expected samples, and directed steps cover timing, config and reset.
module tb_adc_spi_reader;

  logic        clk = 1'b0;
  logic        nreset, enable, sdo, enable2, sdo2;
  logic        adc_convst, adc_sck, adc_sdi, sample_valid;
  logic        adc_convst2, adc_sck2, adc_sdi2, sample_valid2;
  logic [11:0] adc_value, adc_value2;

  adc_spi_reader u_dut (
    .clk(clk), .nreset(nreset), .enable(enable),
    .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(sdo),
    .adc_value(adc_value), .sample_valid(sample_valid)
  );

  adc_spi_reader #(.CLK_DIV(1), .CONV_CYCLES(80), .CHANNEL(5)) u_dut2 (
    .clk(clk), .nreset(nreset), .enable(enable2),
    .adc_convst(adc_convst2), .adc_sck(adc_sck2), .adc_sdi(adc_sdi2), .adc_sdo(sdo2),
    .adc_value(adc_value2), .sample_valid(sample_valid2)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] model_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] exp2_q[$];

  // ADC model 1: word chosen at CONVST rise, D11 after CONVST fall, shifts on SCK fall
  logic [11:0] fr1;
  always @(posedge adc_convst) begin
    if (model_q.size() != 0) fr1 = model_q.pop_front();
    else fr1 = 12'h000;
  end
  always @(negedge adc_convst) sdo = fr1[11];
  always @(negedge adc_sck) begin
    fr1 = {fr1[10:0], 1'b0};
    sdo = fr1[11];
  end

  // ADC model 2 always returns a fixed word
  logic [11:0] fr2;
  always @(posedge adc_convst2) fr2 = 12'h9C3;
  always @(negedge adc_convst2) sdo2 = fr2[11];
  always @(negedge adc_sck2) begin
    fr2 = {fr2[10:0], 1'b0};
    sdo2 = fr2[11];
  end

  int sck_rises = 0, conv_len = 0, last_conv_len = 0, conv_rises = 0;
  int hi_run = 0, sck_bad = 0;
  logic [11:0] sdi_cap2 = '0;

  always @(posedge adc_convst) begin
    conv_len = 0;
    conv_rises++;
  end
  always @(negedge adc_convst) begin
    last_conv_len = conv_len;
    sck_rises = 0;
  end
  always @(posedge adc_sck) sck_rises++;
  always @(negedge clk) begin
    if (adc_convst) conv_len++;
    if (adc_sck) hi_run++;
    else begin
      if (hi_run != 0 && hi_run != 2) sck_bad++;
      hi_run = 0;
    end
    if (adc_sck && adc_convst) sck_bad++;
  end

  always @(negedge adc_convst2) sdi_cap2 = '0;
  always @(posedge adc_sck2) sdi_cap2 = {sdi_cap2[10:0], adc_sdi2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input bit which, input string tag, output int at);
    int n;
    logic v;
    logic [11:0] e;
    n = 0;
    v = 1'b0;
    while (!v && n < 400) begin
      @(negedge clk);
      n++;
      v = which ? sample_valid2 : sample_valid;
    end
    at = cyc;
    check({tag, "_valid_seen"}, 32'(v), 32'd1);
    if (!v) return;
    if (!which) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 12'hxxx;
      check({tag, "_value"}, 32'(adc_value), 32'(e));
      check({tag, "_sck_rises"}, 32'(sck_rises), 32'd12);
      check({tag, "_convst_len"}, 32'(last_conv_len), 32'd80);
    end else begin
      if (exp2_q.size() != 0) e = exp2_q.pop_front();
      else e = 12'hxxx;
      check({tag, "_value"}, 32'(adc_value2), 32'(e));
      check({tag, "_sdi_bits"}, 32'(sdi_cap2), 32'h0000_0E80);
    end
  endtask

  int t0, t1, t2, t3, t4, t5, t6, t7, t8, cr;

  initial begin
    nreset  = 1'b0;
    enable  = 1'b0;
    enable2 = 1'b0;
    sdo     = 1'b0;
    sdo2    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_convst", 32'(adc_convst), 32'd0);
    check("rst_sck", 32'(adc_sck), 32'd0);
    check("rst_sdi", 32'(adc_sdi), 32'd0);
    check("rst_value", 32'(adc_value), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);

    nreset = 1'b1;
    @(negedge clk);
    foreach (model_q[i]) model_q.delete(i);
    model_q.push_back(12'hA5C); exp_q.push_back(12'hA5C);
    model_q.push_back(12'hFFF); exp_q.push_back(12'hFFF);
    model_q.push_back(12'h000); exp_q.push_back(12'h000);
    model_q.push_back(12'h801); exp_q.push_back(12'h801);
    model_q.push_back(12'h3C3); exp_q.push_back(12'h3C3);

    // basic capture and first-frame latency
    enable = 1'b1;
    t0 = cyc;
    wait_valid(0, "basic", t1);
    check("basic_latency", 32'(t1 - t0 - 1), 32'd129);
    @(negedge clk);
    check("pulse_width", 32'(sample_valid), 32'd0);

    // continuous mode with extreme codes
    wait_valid(0, "cont_fff", t2);
    check("period_1", 32'(t2 - t1), 32'd129);
    wait_valid(0, "cont_000", t3);
    check("period_2", 32'(t3 - t2), 32'd129);
    wait_valid(0, "cont_801", t4);
    check("period_3", 32'(t4 - t3), 32'd129);

    // drop enable about 20 cycles into SHIFT of the next frame
    repeat (100) @(negedge clk);
    enable = 1'b0;
    wait_valid(0, "drop", t5);
    check("drop_period", 32'(t5 - t4), 32'd129);
    check("drop_convst", 32'(adc_convst), 32'd0);
    check("drop_sck", 32'(adc_sck), 32'd0);
    check("drop_sdi", 32'(adc_sdi), 32'd0);
    cr = conv_rises;
    repeat (200) @(negedge clk);
    check("idle_no_convst", 32'(conv_rises), 32'(cr));
    check("idle_valid", 32'(sample_valid), 32'd0);
    check("value_hold", 32'(adc_value), 32'h0000_03C3);
    check("sck_shape", 32'(sck_bad), 32'd0);

    // reset ten cycles into SHIFT
    model_q.push_back(12'h5A5);
    enable = 1'b1;
    repeat (91) @(negedge clk);
    #1 nreset = 1'b0;
    #1;
    check("midrst_convst", 32'(adc_convst), 32'd0);
    check("midrst_sck", 32'(adc_sck), 32'd0);
    check("midrst_sdi", 32'(adc_sdi), 32'd0);
    check("midrst_valid", 32'(sample_valid), 32'd0);
    check("midrst_value", 32'(adc_value), 32'd0);
    @(negedge clk);
    model_q.push_back(12'h6B6); exp_q.push_back(12'h6B6);
    nreset = 1'b1;
    t0 = cyc;
    wait_valid(0, "after_rst", t6);
    check("after_rst_latency", 32'(t6 - t0 - 1), 32'd129);
    enable = 1'b0;
    repeat (140) @(negedge clk);

    // CHANNEL=5, CLK_DIV=1 instance
    exp2_q.push_back(12'h9C3);
    exp2_q.push_back(12'h9C3);
    enable2 = 1'b1;
    t0 = cyc;
    wait_valid(1, "ch5_a", t7);
    check("ch5_latency", 32'(t7 - t0 - 1), 32'd105);
    wait_valid(1, "ch5_b", t8);
    check("ch5_period", 32'(t8 - t7), 32'd105);
    enable2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
